// File: rtl/add_pkg.sv
// Shared constants for the carry-lookahead adder.
package add_pkg;
  localparam int GROUP_W    = 4;
  localparam int LENGTH_DEF = 16;
endpackage

// File: rtl/add_16bit_cla4.sv
// 4-bit carry-lookahead cell: local sums plus group generate/propagate
// for the second-level lookahead in the top.
module cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       g,
  output logic       p
);
  logic [3:0] gb, pb, c;

  // bit generate/propagate, flat lookahead carries, group terms
  always_comb begin
    gb   = a & b;
    pb   = a ^ b;
    c[0] = ci;
    c[1] = gb[0] | (pb[0] & ci);
    c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & ci);
    c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
         | (pb[2] & pb[1] & pb[0] & ci);
    s    = pb ^ c;
    g    = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
         | (pb[3] & pb[2] & pb[1] & gb[0]);
    p    = &pb;
  end
endmodule

// File: rtl/add_16bit.sv
// Registered two-level carry-lookahead adder: {Cout,Y} = A + B + Cin,
// one cycle latency, synchronous active-high reset.
module add_16bit
  import add_pkg::*;
#(
  parameter int LENGTH = LENGTH_DEF
) (
  input  logic [LENGTH-1:0] A,
  input  logic [LENGTH-1:0] B,
  input  logic              Cin,
  output logic [LENGTH-1:0] Y,
  output logic              Cout,
  input  logic              clk,
  input  logic              rst
);
  localparam int NG = LENGTH / GROUP_W;

  logic [NG-1:0]     grp_g, grp_p;
  logic [NG:0]       grp_c;
  logic [LENGTH-1:0] sum;
  logic [LENGTH-1:0] y_d, y_q;
  logic              cout_d, cout_q;

  // One lookahead cell per 4-bit group; carry-in comes from the lookahead block.
  for (genvar i = 0; i < NG; i++) begin : g_grp
    cla4 u_cla4 (
      .a  (A[i*GROUP_W +: GROUP_W]),
      .b  (B[i*GROUP_W +: GROUP_W]),
      .ci (grp_c[i]),
      .s  (sum[i*GROUP_W +: GROUP_W]),
      .g  (grp_g[i]),
      .p  (grp_p[i])
    );
  end

  // Second-level lookahead: every group carry is a flat sum of products of
  // group G/P terms and Cin, so no carry ripples from group to group.
  always_comb begin
    logic term, acc;
    term     = 1'b0;
    acc      = 1'b0;
    grp_c    = '0;
    grp_c[0] = Cin;
    for (int i = 1; i <= NG; i++) begin
      term = Cin;
      for (int k = 0; k < i; k++) term = term & grp_p[k];
      acc = term;
      for (int j = 0; j < i; j++) begin
        term = grp_g[j];
        for (int k = j + 1; k < i; k++) term = term & grp_p[k];
        acc = acc | term;
      end
      grp_c[i] = acc;
    end
  end

  // Next-state for the output register; reset overrides operand capture.
  always_comb begin
    y_d    = sum;
    cout_d = grp_c[NG];
    if (rst) begin
      y_d    = '0;
      cout_d = 1'b0;
    end
  end

  // Output register stage.
  always_ff @(posedge clk) begin
    y_q    <= y_d;
    cout_q <= cout_d;
  end

  assign Y    = y_q;
  assign Cout = cout_q;
endmodule

// File: tb/tb_add_16bit.sv
// Scoreboard bench: stimulus pushes the expected 17-bit result at each
// capturing edge; a monitor pops and compares half a cycle later.
module tb_add_16bit;
  localparam int LENGTH = 16;
  localparam int NRAND  = 10000;

  logic [LENGTH-1:0] A, B, Y;
  logic              Cin, Cout, clk, rst;

  logic [LENGTH:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  bit done  = 0;

  add_16bit #(.LENGTH(LENGTH)) dut (
    .A(A), .B(B), .Cin(Cin), .Y(Y), .Cout(Cout), .clk(clk), .rst(rst)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Reference: plain unsigned addition at LENGTH+1 bits, zero under reset.
  function automatic logic [LENGTH:0] ref_sum(logic [LENGTH-1:0] a, logic [LENGTH-1:0] b,
                                              logic c, logic r);
    logic [LENGTH:0] s;
    s = {1'b0, a} + {1'b0, b} + {{LENGTH{1'b0}}, c};
    return r ? '0 : s;
  endfunction

  task automatic apply(logic [LENGTH-1:0] a, logic [LENGTH-1:0] b, logic c, logic r);
    A = a; B = b; Cin = c; rst = r;
    @(posedge clk);
    exp_q.push_back(ref_sum(a, b, c, r));
    #1;
  endtask

  // Monitor: one result per edge, checked on the falling edge.
  initial begin
    logic [LENGTH:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total++;
        if ({Cout, Y} !== e) begin
          bad++;
          if (bad <= 20)
            $display("FAIL sum #%0d: got Cout=%b Y=%h, want Cout=%b Y=%h",
                     total, Cout, Y, e[LENGTH], e[LENGTH-1:0]);
        end
      end
    end
  end

  initial begin
    A = '0; B = '0; Cin = 0; rst = 1;
    #1;
    // reset with all-ones operands present: must read 0/0 throughout
    apply(16'hFFFF, 16'hFFFF, 1, 1);
    apply(16'hFFFF, 16'hFFFF, 1, 1);
    // directed vectors
    apply(16'h0000, 16'h0000, 0, 0);
    apply(16'h0000, 16'h0000, 1, 0);
    apply(16'hFFFF, 16'hFFFF, 0, 0);
    apply(16'hFFFF, 16'hFFFF, 1, 0);
    apply(16'hFFFF, 16'h0000, 0, 0);
    apply(16'hFFFF, 16'h0000, 1, 0);
    apply(16'h1234, 16'h4321, 0, 0);
    apply(16'h8000, 16'h8000, 0, 0);
    apply(16'hAAAA, 16'h5555, 1, 1);   // mid-stream reset
    apply(16'h0FFF, 16'h0001, 0, 0);
    apply(16'h00FF, 16'hFF00, 1, 0);   // carry ripples through every group
    // random regression with occasional reset and boundary-biased operands
    for (int n = 0; n < NRAND; n++) begin
      logic [LENGTH-1:0] a, b;
      a = LENGTH'($urandom);
      b = LENGTH'($urandom);
      case ($urandom_range(0, 15))
        0: a = '1;
        1: b = '1;
        2: b = ~a;
        default: ;
      endcase
      apply(a, b, 1'($urandom), ($urandom_range(0, 99) == 0));
    end
    rst = 0;
    // drain with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d results left unchecked, want 0", exp_q.size());
    end
    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Overall time guard.
  initial begin
    #2000000;
    if (!done) begin
      $display("FAIL timeout: bench did not complete, want completion");
      $fatal(1, "timeout");
    end
  end
endmodule

// File: doc/add_16bit.md
ADD_16BIT -- requirements
Module: add_16bit

Interface
REQ-001 Parameter: LENGTH, default 16, operand/sum width in bits; SHALL be a positive multiple of 4.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: A  input  LENGTH  addend A, unsigned.
REQ-005 Port: B  input  LENGTH  addend B, unsigned.
REQ-006 Port: Cin  input  1  carry-in.
REQ-007 Port: Y  output  LENGTH  registered sum bits.
REQ-008 Port: Cout  output  1  registered carry-out.
REQ-009 Positional port order SHALL be A, B, Cin, Y, Cout, clk, rst, so existing 5-port positional instantiations bind the data ports unchanged.
REQ-010 Clock is one domain (clk); reset is synchronous, active-high (rst).

Function
REQ-011 {Cout, Y} SHALL equal A + B + Cin computed at full LENGTH+1 width, unsigned, no saturation.
REQ-012 Latency SHALL be exactly 1 clock: values of A, B, Cin sampled at rising edge N appear on Y/Cout after edge N and hold until edge N+1.
REQ-013 No handshake; a new operand set is accepted every cycle (throughput 1/cycle).
REQ-014 Overflow: carry out of bit LENGTH-1 SHALL appear only on Cout; Y wraps modulo 2^LENGTH.
REQ-015 Boundary: all-ones + all-ones + 1 SHALL give Y = all-ones, Cout = 1 (maximum result 2^(LENGTH+1)-1).
REQ-016 Boundary: all-ones + 0 + 1 SHALL give Y = 0, Cout = 1 (full carry ripple through every group).
REQ-017 Sum logic SHALL be two-level carry-lookahead: 4-bit groups produce group generate/propagate; a lookahead stage computes every group carry-in from Cin; no bit-serial ripple across groups.
REQ-018 Combinational path SHALL contain no latches; outputs SHALL never be X once reset has been applied.

Reset
REQ-019 While rst is high at a rising edge, Y SHALL load 0 and Cout SHALL load 0.
REQ-020 rst takes priority over operand capture; result of operands present on a reset edge is discarded.
REQ-021 On the first edge with rst low, normal capture resumes; first valid result follows 1 cycle later.
REQ-022 Before the first reset edge, output values are undefined.

Structure
REQ-023 Shared package add_pkg SHALL hold GROUP_W = 4 and the default LENGTH = 16.
REQ-024 One sub-module cla4: 4-bit lookahead cell, inputs a[3:0], b[3:0], ci; outputs s[3:0], group g, group p.
REQ-025 Top SHALL instantiate LENGTH/4 cla4 cells via generate, a group-carry lookahead block, and the output register stage.

Verification
REQ-026 rst=1 for 2 cycles with A=B=FFFF, Cin=1 -> Y=0000, Cout=0 throughout reset.
REQ-027 A=0000,B=0000,Cin=0 -> Y=0000,Cout=0; then Cin=1 -> Y=0001,Cout=0, each 1 cycle after apply.
REQ-028 A=FFFF,B=FFFF,Cin=0 -> Y=FFFE,Cout=1; Cin=1 -> Y=FFFF,Cout=1.
REQ-029 A=FFFF,B=0000,Cin=0 -> Y=FFFF,Cout=0; Cin=1 -> Y=0000,Cout=1.
REQ-030 Back-to-back operands each cycle (e.g. 1234+4321+0 then 8000+8000+0) -> 5555/0 then 0000/1 on consecutive cycles; rst asserted mid-stream -> next output 0000/0.
REQ-031 Random regression, 10k vectors, compared against a 17-bit reference sum delayed 1 cycle.
